// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared FSM state encoding and requester ids for the dmem arbiter
package dmem_arb_pkg;
    typedef enum logic [1:0] {ARB = 2'd0, LOCK0 = 2'd1, LOCK1 = 2'd2} arb_state_t;
    localparam int M0 = 0;
    localparam int M1 = 1;
endpackage

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: one-hot grant between two requesters, ptr=1 favours requester 1 on a tie
module dmem_arb_pick import dmem_arb_pkg::*; (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);
    // each requester wins unless the other also asks and is favoured
    always_comb begin
        gnt     = 2'b00;
        gnt[M0] = req[M0] & ~(req[M1] & ptr);
        gnt[M1] = req[M1] & ~(req[M0] & ~ptr);
    end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester dmem arbiter with grant locking; DMEM_ARB_RR_EN enables round-robin ties
module dmem_arbiter import dmem_arb_pkg::*; #(
    parameter int ADDR_W   = 11,
    parameter int LOCK_MAX = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_read,
    input  logic [3:0]        m0_writeb,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [31:0]       m0_wdata,
    input  logic              m0_lock,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [31:0]       m0_rdata,
    input  logic              m1_req,
    input  logic              m1_read,
    input  logic [3:0]        m1_writeb,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [31:0]       m1_wdata,
    input  logic              m1_lock,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [31:0]       m1_rdata,
    output logic              dmem_read,
    output logic [3:0]        dmem_writeb,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic [31:0]       dmem_rdata
);
    localparam logic [7:0] LOCK_INIT = 8'(LOCK_MAX - 1);
    localparam bit         LOCK_EN   = LOCK_MAX > 1;
    arb_state_t state, state_nx;
    logic [7:0] cnt, cnt_nx;
    logic [1:0] req, pick_gnt, gnt;
    logic       ptr, rv0, rv1;
    assign req = {m1_req, m0_req};
`ifdef DMEM_ARB_RR_EN
    logic ptr_q;
    // the last granted requester loses the next tie
    always_ff @(posedge clk or posedge reset)
        if (reset) ptr_q <= 1'b0;
        else if (|gnt) ptr_q <= gnt[M0];
    assign ptr = ptr_q;
`else
    assign ptr = 1'b0;
`endif
    dmem_arb_pick u_pick (.req(req), .ptr(ptr), .gnt(pick_gnt));
    // grant selection and lock-state next-state logic; lock exit clears the counter
    always_comb begin
        gnt      = 2'b00;
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            ARB: begin
                gnt = pick_gnt;
                if (LOCK_EN && gnt[M0] && m0_lock) begin
                    state_nx = LOCK0;
                    cnt_nx   = LOCK_INIT;
                end else if (LOCK_EN && gnt[M1] && m1_lock) begin
                    state_nx = LOCK1;
                    cnt_nx   = LOCK_INIT;
                end
            end
            LOCK0: begin
                gnt[M0]  = m0_req;
                state_nx = (!m0_req || !m0_lock || cnt <= 8'd1) ? ARB : LOCK0;
                cnt_nx   = (state_nx == ARB) ? 8'd0 : cnt - 8'd1;
            end
            LOCK1: begin
                gnt[M1]  = m1_req;
                state_nx = (!m1_req || !m1_lock || cnt <= 8'd1) ? ARB : LOCK1;
                cnt_nx   = (state_nx == ARB) ? 8'd0 : cnt - 8'd1;
            end
            default: begin
                state_nx = ARB;
                cnt_nx   = 8'd0;
            end
        endcase
        if (reset) gnt = 2'b00;
    end
    // state and lock counter registers
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= ARB;
            cnt   <= 8'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    // read-valid pipeline: one cycle after a granted read, independent of FSM state
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            rv0 <= 1'b0;
            rv1 <= 1'b0;
        end else begin
            rv0 <= gnt[M0] & m0_read;
            rv1 <= gnt[M1] & m1_read;
        end
    assign m0_gnt      = gnt[M0];
    assign m1_gnt      = gnt[M1];
    assign m0_rvalid   = rv0;
    assign m1_rvalid   = rv1;
    assign m0_rdata    = rv0 ? dmem_rdata : 32'd0;
    assign m1_rdata    = rv1 ? dmem_rdata : 32'd0;
    assign dmem_read   = gnt[M0] ? m0_read   : gnt[M1] ? m1_read   : 1'b0;
    assign dmem_writeb = gnt[M0] ? m0_writeb : gnt[M1] ? m1_writeb : 4'd0;
    assign dmem_addr   = gnt[M0] ? m0_addr   : gnt[M1] ? m1_addr   : '0;
    assign dmem_wdata  = gnt[M0] ? m0_wdata  : gnt[M1] ? m1_wdata  : 32'd0;
endmodule
